// File: rtl/fetch_inst_queue_pkg.sv
// Shared fetch/decode/rename packet types used by the front end.
// f_d_pkg_t is the fetch-to-decode packet; fq_entry_t is one stored instruction.
package fetch_inst_queue_pkg;

    localparam int FETCH_WIDTH  = 2;
    localparam int DECODE_WIDTH = 2;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0][31:0] pc;
        logic [FETCH_WIDTH-1:0]       mask;
    } preict_info_t;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0][31:0] insts;
        preict_info_t                 preict_info;
    } f_d_pkg_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [4:0]  rj;
        logic [4:0]  rk;
        logic [31:0] imm;
        logic [7:0]  op;
    } decoder_info_t;

    typedef struct packed {
        decoder_info_t [DECODE_WIDTH-1:0] info;
        logic [DECODE_WIDTH-1:0][31:0]    pc;
        logic [DECODE_WIDTH-1:0]          mask;
    } d_r_pkg_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fq_entry_t;

    function automatic logic [1:0] popcount2(input logic [1:0] m);
        return {1'b0, m[0]} + {1'b0, m[1]};
    endfunction

endpackage

// File: rtl/handshake_if.sv
// Valid/ready channel carrying a fetch-to-decode packet.
// A transfer happens on a clock edge where valid and ready are both 1; data is stable while valid is held.
interface handshake_if;
    logic                            valid;
    logic                            ready;
    fetch_inst_queue_pkg::f_d_pkg_t  data;

    modport sender   (output valid, output data, input  ready);
    modport receiver (input  valid, input  data, output ready);
endinterface

// File: rtl/fetch_queue_bank.sv
// Instruction storage for the fetch queue: DEPTH entries, two write ports, two combinational read ports.
// Contents are never reset; only the pointers in the parent give them meaning.
module fetch_queue_bank
    import fetch_inst_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic [FETCH_WIDTH-1:0]           we_i,
    input  logic [FETCH_WIDTH-1:0][IW-1:0]   widx_i,
    input  fq_entry_t [FETCH_WIDTH-1:0]      wdata_i,
    input  logic [FETCH_WIDTH-1:0][IW-1:0]   ridx_i,
    output fq_entry_t [FETCH_WIDTH-1:0]      rdata_o
);

    fq_entry_t mem_q [DEPTH];

    // Write indices are always distinct (tail and tail+1), so port order does not matter.
    always_ff @(posedge clk) begin
        for (int w = 0; w < FETCH_WIDTH; w++) begin
            if (we_i[w]) begin
                mem_q[widx_i[w]] <= wdata_i[w];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < FETCH_WIDTH; r++) begin
            rdata_o[r] = mem_q[ridx_i[r]];
        end
    end

endmodule

// File: rtl/fetch_inst_queue.sv
// Fetch-to-decode instruction queue: stores 2-wide fetch groups per instruction and presents head-compacted packets.
// Optional same-cycle empty-queue bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_inst_queue
    import fetch_inst_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic                          f_valid_i,
    output logic                          f_ready_o,
    input  logic [FETCH_WIDTH-1:0][31:0]  f_pc_i,
    input  logic [FETCH_WIDTH-1:0][31:0]  f_inst_i,
    input  logic [FETCH_WIDTH-1:0]        f_mask_i,
    handshake_if.sender                   sender
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] SPACE_LIM = PW'(DEPTH - FETCH_WIDTH);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] count;
    logic [IW-1:0] head_idx, tail_idx;

    logic          fire;
    logic          pop;
    logic          bypass_hit;
    logic          bypass_take;
    logic [1:0]    push_n;
    logic [1:0]    pop_n;
    logic [1:0]    q_mask;
    logic          out_valid;
    f_d_pkg_t      out_data;

    logic [FETCH_WIDTH-1:0]         we;
    logic [FETCH_WIDTH-1:0][IW-1:0] widx;
    fq_entry_t [FETCH_WIDTH-1:0]    wdata;
    logic [FETCH_WIDTH-1:0][IW-1:0] ridx;
    fq_entry_t [FETCH_WIDTH-1:0]    rdata;

    assign count    = tail_q - head_q;
    assign head_idx = head_q[IW-1:0];
    assign tail_idx = tail_q[IW-1:0];

    // Ready is judged on the current count only; a same-cycle pop gives no credit.
    assign f_ready_o = (count <= SPACE_LIM) & ~flush_i;
    assign fire      = f_valid_i & f_ready_o;

    assign q_mask = (count >= PW'(2)) ? 2'b11 :
                    (count == PW'(1)) ? 2'b01 : 2'b00;

    // Write compaction: the first valid slot always lands at tail.
    always_comb begin
        we       = '0;
        widx[0]  = tail_idx;
        widx[1]  = tail_idx + IW'(1);
        wdata[0] = f_mask_i[0] ? '{pc: f_pc_i[0], inst: f_inst_i[0]}
                               : '{pc: f_pc_i[1], inst: f_inst_i[1]};
        wdata[1] = '{pc: f_pc_i[1], inst: f_inst_i[1]};
        if (fire && !bypass_take) begin
            we[0] = |f_mask_i;
            we[1] = &f_mask_i;
        end
    end

    assign ridx[0] = head_idx;
    assign ridx[1] = head_idx + IW'(1);

    fetch_queue_bank #(
        .DEPTH (DEPTH)
    ) u_bank (
        .clk     (clk),
        .we_i    (we),
        .widx_i  (widx),
        .wdata_i (wdata),
        .ridx_i  (ridx),
        .rdata_o (rdata)
    );

    always_comb begin
        out_valid                   = (count != '0) & ~flush_i;
        out_data.insts[0]           = rdata[0].inst;
        out_data.insts[1]           = rdata[1].inst;
        out_data.preict_info.pc[0]  = rdata[0].pc;
        out_data.preict_info.pc[1]  = rdata[1].pc;
        out_data.preict_info.mask   = q_mask;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_hit = (count == '0) & fire & (|f_mask_i);
        if (bypass_hit) begin
            out_valid                  = 1'b1;
            out_data.insts[0]          = f_mask_i[0] ? f_inst_i[0] : f_inst_i[1];
            out_data.insts[1]          = f_inst_i[1];
            out_data.preict_info.pc[0] = f_mask_i[0] ? f_pc_i[0] : f_pc_i[1];
            out_data.preict_info.pc[1] = f_pc_i[1];
            out_data.preict_info.mask  = (&f_mask_i) ? 2'b11 : 2'b01;
        end
`else
        bypass_hit = 1'b0;
`endif
    end

    assign bypass_take  = bypass_hit & sender.ready;
    assign sender.valid = out_valid;
    assign sender.data  = out_data;

    // A bypassed group never touched storage, so it must not advance head either.
    assign pop    = out_valid & sender.ready & ~bypass_hit;
    assign pop_n  = pop ? popcount2(q_mask) : 2'b00;
    assign push_n = (fire && !bypass_take) ? popcount2(f_mask_i) : 2'b00;

    always_comb begin
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            head_d = head_q + PW'(pop_n);
            tail_d = tail_q + PW'(push_n);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed bench for fetch_inst_queue with a reference queue of expected pcs (inst words are ~pc).
module tb_fetch_inst_queue;
    import fetch_inst_queue_pkg::*;

    localparam int DEPTH = 8;

    logic                         clk;
    logic                         rst;
    logic                         flush_i;
    logic                         f_valid_i;
    logic                         f_ready_o;
    logic [FETCH_WIDTH-1:0][31:0] f_pc_i;
    logic [FETCH_WIDTH-1:0][31:0] f_inst_i;
    logic [FETCH_WIDTH-1:0]       f_mask_i;

    handshake_if hs ();

    fetch_inst_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush_i),
        .f_valid_i (f_valid_i),
        .f_ready_o (f_ready_o),
        .f_pc_i    (f_pc_i),
        .f_inst_i  (f_inst_i),
        .f_mask_i  (f_mask_i),
        .sender    (hs)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard
    logic [31:0] exp_q[$];
    int n_checks;
    int n_fail;

    function automatic int pc2(input logic [1:0] m);
        return int'(m[0]) + int'(m[1]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, update the model, advance.
    task automatic step(input logic fv, input logic [1:0] m, input logic [31:0] pc0, input logic [31:0] pc1,
                        input logic rdy, input logic fl, output logic fired);
        int          sz;
        logic        exp_rdy;
        logic        exp_vld;
        logic        byp;
        logic [1:0]  exp_mask;
        logic [31:0] e0;
        logic [31:0] e1;
        f_valid_i   = fv;
        f_mask_i    = m;
        f_pc_i[0]   = pc0;
        f_pc_i[1]   = pc1;
        f_inst_i[0] = ~pc0;
        f_inst_i[1] = ~pc1;
        hs.ready    = rdy;
        flush_i     = fl;
        #2;
        sz       = exp_q.size();
        exp_rdy  = (DEPTH - sz >= 2) && !fl;
        fired    = fv && exp_rdy;
        exp_vld  = (sz >= 1) && !fl;
        exp_mask = (sz >= 2) ? 2'b11 : (sz == 1) ? 2'b01 : 2'b00;
        e0       = (sz >= 1) ? exp_q[0] : 32'h0;
        e1       = (sz >= 2) ? exp_q[1] : 32'h0;
        byp      = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (sz == 0 && fired && m != 2'b00) begin
            byp      = 1'b1;
            exp_vld  = 1'b1;
            exp_mask = (m == 2'b11) ? 2'b11 : 2'b01;
            e0       = m[0] ? pc0 : pc1;
            e1       = pc1;
        end
`endif
        check("f_ready_o", 32'(f_ready_o), 32'(exp_rdy));
        check("sender_valid", 32'(hs.valid), 32'(exp_vld));
        if (exp_vld) begin
            check("mask", 32'(hs.data.preict_info.mask), 32'(exp_mask));
            check("pc0", hs.data.preict_info.pc[0], e0);
            check("inst0", hs.data.insts[0], ~e0);
            if (exp_mask[1]) begin
                check("pc1", hs.data.preict_info.pc[1], e1);
                check("inst1", hs.data.insts[1], ~e1);
            end
        end
        // Invariants on what the DUT offers: no push past DEPTH, no pop past count.
        if (f_ready_o && fv)
            check("push_bound", 32'(sz + pc2(m) <= DEPTH), 32'd1);
        if (hs.valid && rdy && !byp)
            check("pop_bound", 32'(pc2(hs.data.preict_info.mask) <= sz), 32'd1);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (exp_vld && rdy && !byp)
                repeat (pc2(exp_mask)) void'(exp_q.pop_front());
            if (fired && !(byp && rdy)) begin
                if (m[0]) exp_q.push_back(pc0);
                if (m[1]) exp_q.push_back(pc1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Hold inputs idle and compare the visible packet against literal values.
    task automatic expect_pkt(input string tag, input logic [1:0] m, input logic [31:0] p0, input logic [31:0] p1);
        f_valid_i = 1'b0;
        flush_i   = 1'b0;
        hs.ready  = 1'b0;
        #1;
        check({tag, "_valid"}, 32'(hs.valid), 32'(m != 2'b00));
        check({tag, "_mask"}, 32'(hs.data.preict_info.mask), 32'(m));
        if (m != 2'b00) check({tag, "_pc0"}, hs.data.preict_info.pc[0], p0);
        if (m == 2'b11) check({tag, "_pc1"}, hs.data.preict_info.pc[1], p1);
    endtask

    initial begin
        logic        fired;
        logic [31:0] pc_seq;
        int          fires;
        int          guard;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        flush_i   = 1'b0;
        f_valid_i = 1'b0;
        f_mask_i  = 2'b00;
        f_pc_i    = '0;
        f_inst_i  = '0;
        hs.ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_f_ready", 32'(f_ready_o), 32'd1);
        check("reset_valid", 32'(hs.valid), 32'd0);
        check("reset_mask", 32'(hs.data.preict_info.mask), 32'd0);

        // Full group becomes visible one cycle later, then drains.
        step(1'b1, 2'b11, 32'h1c000000, 32'h1c000004, 1'b1, 1'b0, fired);
        expect_pkt("t1", 2'b11, 32'h1c000000, 32'h1c000004);
        step(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, fired);
        expect_pkt("t1_empty", 2'b00, 32'h0, 32'h0);

        // Single-slot groups compact into one packet.
        step(1'b1, 2'b10, 32'h1c000010, 32'h1c000014, 1'b0, 1'b0, fired);
        step(1'b1, 2'b01, 32'h1c000018, 32'h1c00001c, 1'b0, 1'b0, fired);
        expect_pkt("t2", 2'b11, 32'h1c000014, 32'h1c000018);
        step(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, fired);

        // Fill to DEPTH-1: ready drops, the offered group is dropped, one pop restores ready.
        step(1'b1, 2'b11, 32'h20000000, 32'h20000004, 1'b0, 1'b0, fired);
        step(1'b1, 2'b11, 32'h20000008, 32'h2000000c, 1'b0, 1'b0, fired);
        step(1'b1, 2'b11, 32'h20000010, 32'h20000014, 1'b0, 1'b0, fired);
        step(1'b1, 2'b01, 32'h20000018, 32'h2000001c, 1'b0, 1'b0, fired);
        f_valid_i = 1'b1;
        #1;
        check("t3_full_ready", 32'(f_ready_o), 32'd0);
        step(1'b1, 2'b11, 32'hbad00000, 32'hbad00004, 1'b0, 1'b0, fired);
        step(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, fired);
        #1;
        check("t3_ready_back", 32'(f_ready_o), 32'd1);
        repeat (4) step(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, fired);
        expect_pkt("t3_empty", 2'b00, 32'h0, 32'h0);

        // Random streaming across pointer wrap.
        pc_seq = 32'h30000000;
        fires  = 0;
        guard  = 0;
        while (fires < 200 && guard < 2000) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), pc_seq, pc_seq + 32'd4,
                 1'($urandom_range(0, 1)), 1'b0, fired);
            if (fired) begin
                fires++;
                pc_seq = pc_seq + 32'd8;
            end
            guard++;
        end
        check("t4_group_budget", 32'(fires), 32'd200);
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            step(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, fired);
            guard++;
        end
        expect_pkt("t4_empty", 2'b00, 32'h0, 32'h0);

        // Flush with 5 entries and a group on the input.
        step(1'b1, 2'b11, 32'h40000000, 32'h40000004, 1'b0, 1'b0, fired);
        step(1'b1, 2'b11, 32'h40000008, 32'h4000000c, 1'b0, 1'b0, fired);
        step(1'b1, 2'b01, 32'h40000010, 32'h40000014, 1'b0, 1'b0, fired);
        step(1'b1, 2'b11, 32'hdead0000, 32'hdead0004, 1'b1, 1'b1, fired);
        expect_pkt("t5_after_flush", 2'b00, 32'h0, 32'h0);
        check("t5_ready_after", 32'(f_ready_o), 32'd1);
        step(1'b1, 2'b11, 32'h50000000, 32'h50000004, 1'b0, 1'b0, fired);
        expect_pkt("t5_next", 2'b11, 32'h50000000, 32'h50000004);
        step(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, fired);

`ifdef FETCH_QUEUE_BYPASS_EN
        // Empty-queue bypass: consumed in the same cycle, nothing stored.
        step(1'b1, 2'b11, 32'h60000000, 32'h60000004, 1'b1, 1'b0, fired);
        expect_pkt("t6_empty", 2'b00, 32'h0, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
